lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store controller sitting directly upstream of the byte-addressed data memory.
//  Takes one pipeline load/store request (RV32I funct3), drives the memory's word port,
//  and returns sign/zero-extended load data.
//  Sub-word stores (SB/SH) become read-modify-write, because the memory writes 4 bytes per enable.
// PARAMETERS
//  WIDTH      32  data/address width
//  ADDR_BITS  17  memory index bits; forwarded address is the full req_addr
// PORTS
//  clk               in   1      single clock, rising edge
//  rst_n             in   1      asynchronous, active-low reset
//  req_valid         in   1      request present
//  req_ready         out  1      controller can accept (IDLE only)
//  req_we            in   1      1=store, 0=load
//  req_funct3        in   3      000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU: loads only)
//  req_addr          in   WIDTH  byte address
//  req_wdata         in   WIDTH  store data (low bytes used for B/H)
//  resp_valid        out  1      one-cycle pulse; request complete; no backpressure
//  resp_rdata        out  WIDTH  extended load data; 0 for stores and errors
//  resp_err          out  1      illegal funct3 (or misaligned, see CONFIGURATION)
//  mem_adr           out  WIDTH  to data memory adr
//  mem_write_data    out  WIDTH  to data memory write_data
//  mem_write_enable  out  1      to data memory write_enable
//  mem_read_data     in   WIDTH  from data memory (combinational read)
// BEHAVIOUR
//  States: IDLE, ACCESS, MERGE_WR, RESP.
//  Reset: state=IDLE. All regs 0.
//   req_ready=0 while rst_n=0, 1 after release.
//   resp_valid=0, resp_rdata=0, resp_err=0, mem_adr=0, mem_write_data=0.
//   mem_write_enable decodes from state only, so it drops to 0 as soon as rst_n asserts.
//  IDLE: req_ready=1. On req_valid&&req_ready at edge T, capture we/funct3/addr/wdata -> ACCESS.
//  Error check: illegal funct3 (load 011/110/111; store other than 000/001/010).
//   On error -> RESP with err=1; no memory write.
//  ACCESS (T+1): mem_adr=addr_q.
//   Load: extend mem_read_data, register into rdata_q -> RESP.
//    B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
//   SW: mem_write_enable=1, mem_write_data=wdata_q -> RESP.
//   SB/SH: capture merge_q -> MERGE_WR.
//    SB: merge_q={rd[31:8],wdata_q[7:0]}.
//    SH: merge_q={rd[31:16],wdata_q[15:0]}.
//  MERGE_WR (T+2): mem_adr=addr_q, mem_write_enable=1, mem_write_data=merge_q -> RESP.
//  RESP: resp_valid=1 for exactly one cycle, resp_rdata/resp_err valid -> IDLE.
//  Latency, accept edge T to resp_valid cycle: load/SW/error T+2; SB/SH T+3.
//  req_ready=0 outside IDLE. req_valid held while busy is ignored until IDLE, not queued.
//  mem_write_enable is high in at most one cycle per request.
//   It is never high in IDLE, RESP, or on error.
//  Reset mid-operation: request aborted, no resp_valid. Write never issued if reset precedes MERGE_WR.
//  Addresses within 3 bytes of 2**ADDR_BITS are outside the supported range; no wrap guarantee.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: in the error check, H/HU with addr[0]!=0, or W with addr[1:0]!=0,
//   is flagged as an error -> RESP, resp_err=1, no memory access, rdata 0.
//  LSU_MISALIGN_TRAP_EN not defined: misaligned accesses proceed normally.
//   Memory serves bytes addr..addr+3 directly. resp_err only for illegal funct3.
// TESTING
//  1 Reset:
//    rst_n=0 -> all outputs 0. Release -> req_ready=1 next cycle.
//  2 SW 0xDEADBEEF @0x100, then LW @0x100:
//    mem_write_enable 1 cycle at T+1. Load resp_valid at T+2, rdata=0xDEADBEEF.
//  3 SB 0x80 @0x100, mem=0xDEADBEEF:
//    write 0xDEADBE80 at T+2, resp at T+3.
//    Then LB -> 0xFFFFFF80; LBU -> 0x00000080.
//  4 SH 0x1234 @0x100 over 0xDEADBEEF:
//    mem=0xDEAD1234. LH -> 0x00001234. LHU after SH 0x8001 -> 0x00008001.
//  5 LW @0x101, bytes 0x101..0x104 = 11,22,33,44:
//    macro on -> resp_err=1, rdata=0, no write.
//    macro off -> rdata=0x44332211, resp_err=0.
//  6 rst_n pulsed low during MERGE_WR entry of SB:
//    no write (word unchanged, LW re-reads 0xDEADBEEF), no resp_valid, state IDLE.
//    funct3=011 store -> resp_err=1, no write.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word-write, byte-addressed data memory; SB/SH use read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN: flag misaligned H/HU/W accesses as errors instead of performing them.
module lsu_mem_ctrl #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_write_data,
    output logic             mem_write_enable,
    input  logic [WIDTH-1:0] mem_read_data
);

    if (ADDR_BITS > WIDTH) begin : g_bad_cfg
        $error("ADDR_BITS must not exceed WIDTH");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;

    state_t           state, state_nx;
    logic             we_q, err_q, req_err;
    logic [2:0]       f3_q;
    logic [WIDTH-1:0] addr_q, wdata_q, merge_q, rdata_q;
    logic [WIDTH-1:0] load_ext, merge_nx;

    always_comb begin
        req_err = 1'b0;
        if (req_we)
            req_err = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        else
            req_err = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
`endif
    end

    always_comb begin
        load_ext = mem_read_data;
        case (f3_q)
            3'b000:  load_ext = {{(WIDTH-8){mem_read_data[7]}}, mem_read_data[7:0]};
            3'b001:  load_ext = {{(WIDTH-16){mem_read_data[15]}}, mem_read_data[15:0]};
            3'b100:  load_ext = {{(WIDTH-8){1'b0}}, mem_read_data[7:0]};
            3'b101:  load_ext = {{(WIDTH-16){1'b0}}, mem_read_data[15:0]};
            default: load_ext = mem_read_data;
        endcase
    end

    // Sub-word store: keep the untouched upper bytes of the current word.
    assign merge_nx = f3_q[0] ? {mem_read_data[WIDTH-1:16], wdata_q[15:0]}
                              : {mem_read_data[WIDTH-1:8],  wdata_q[7:0]};

    always_comb begin
        state_nx         = state;
        mem_write_enable = 1'b0;
        mem_write_data   = '0;
        case (state)
            IDLE: begin
                if (req_valid)
                    state_nx = ACCESS;
            end
            ACCESS: begin
                state_nx = RESP;
                if (!err_q && we_q) begin
                    if (f3_q == 3'b010) begin
                        mem_write_enable = 1'b1;
                        mem_write_data   = wdata_q;
                    end else begin
                        state_nx = MERGE_WR;
                    end
                end
            end
            MERGE_WR: begin
                mem_write_enable = 1'b1;
                mem_write_data   = merge_q;
                state_nx         = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                    end
                end
                ACCESS: begin
                    rdata_q <= (!err_q && !we_q) ? load_ext : '0;
                    merge_q <= merge_nx;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = rst_n && (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = (state == RESP) ? rdata_q : '0;
    assign resp_err   = (state == RESP) && err_q;
    assign mem_adr    = addr_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: byte-array memory, byte-level reference model, directed and random requests.
module tb_lsu_mem_ctrl;
    localparam int W  = 32;
    localparam int AB = 17;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = '0;
    logic [W-1:0]  req_addr = '0;
    logic [W-1:0]  req_wdata = '0;
    logic          resp_valid;
    logic [W-1:0]  resp_rdata;
    logic          resp_err;
    logic [W-1:0]  mem_adr;
    logic [W-1:0]  mem_write_data;
    logic          mem_write_enable;
    logic [W-1:0]  mem_read_data;

    int checks = 0;
    int failures = 0;

    lsu_mem_ctrl #(.WIDTH(W), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_adr(mem_adr), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Data memory: combinational little-endian word read, 4-byte write per enable.
    logic [7:0]    mem [0:(1<<AB)-1];
    logic [AB-1:0] wa;
    assign wa = mem_adr[AB-1:0];
    assign mem_read_data = {mem[wa + AB'(3)], mem[wa + AB'(2)], mem[wa + AB'(1)], mem[wa]};
    always @(posedge clk)
        if (mem_write_enable)
            for (int k = 0; k < 4; k++)
                mem[wa + AB'(k)] <= mem_write_data[8*k +: 8];

    logic [7:0] ref_mem [0:511];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-granular view of RV32I load/store semantics.
    task automatic model(input logic we, input logic [2:0] f3, input logic [W-1:0] a,
                         input logic [W-1:0] wd, output logic err, output logic [W-1:0] rd,
                         output int nwr, output int wlat, output int lat);
        int sz;
        bit sgn;
        int base;
        sz = 0; sgn = 0;
        if (we) begin
            case (f3)
                3'b000:  sz = 1;
                3'b001:  sz = 2;
                3'b010:  sz = 4;
                default: sz = 0;
            endcase
        end else begin
            case (f3)
                3'b000:  begin sz = 1; sgn = 1; end
                3'b001:  begin sz = 2; sgn = 1; end
                3'b010:  sz = 4;
                3'b100:  sz = 1;
                3'b101:  sz = 2;
                default: sz = 0;
            endcase
        end
        err = (sz == 0);
`ifdef LSU_MISALIGN_TRAP_EN
        if (sz == 2 && a[0]) err = 1'b1;
        if (sz == 4 && a[1:0] != 2'b00) err = 1'b1;
`endif
        rd = '0; nwr = 0; wlat = 0; lat = 2;
        base = int'(a[8:0]);
        if (!err) begin
            if (we) begin
                for (int k = 0; k < sz; k++)
                    ref_mem[(base + k) % 512] = wd[8*k +: 8];
                nwr  = 1;
                wlat = (sz == 4) ? 1 : 2;
                lat  = (sz == 4) ? 2 : 3;
            end else begin
                for (int k = 0; k < sz; k++)
                    rd[8*k +: 8] = ref_mem[(base + k) % 512];
                if (sgn && rd[8*sz-1])
                    for (int k = sz; k < 4; k++)
                        rd[8*k +: 8] = 8'hFF;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [W-1:0] a,
                          input logic [W-1:0] wd, output logic [W-1:0] got);
        logic         e_err, g_err;
        logic [W-1:0] e_rd;
        int           e_nwr, e_wlat, e_lat, lat, nwr, wlat;
        bit           busy_ok;
        model(we, f3, a, wd, e_err, e_rd, e_nwr, e_wlat, e_lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; nwr = 0; wlat = 0; busy_ok = 1; got = '0; g_err = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_write_enable) begin nwr++; wlat = k; end
            if (req_ready) busy_ok = 0;
            if (resp_valid) begin
                lat = k; got = resp_rdata; g_err = resp_err;
                break;
            end
        end
        chk($sformatf("latency we=%0b f3=%0d a=%h", we, f3, a), W'(lat), W'(e_lat));
        chk($sformatf("rdata we=%0b f3=%0d a=%h", we, f3, a), got, e_rd);
        chk($sformatf("err we=%0b f3=%0d a=%h", we, f3, a), W'(g_err), W'(e_err));
        chk($sformatf("writes we=%0b f3=%0d a=%h", we, f3, a), W'(nwr), W'(e_nwr));
        chk("ready_low_while_busy", W'(busy_ok), 32'd1);
        if (e_nwr != 0)
            chk($sformatf("write_cycle f3=%0d a=%h", f3, a), W'(wlat), W'(e_wlat));
    endtask

    logic [W-1:0] got;

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready", W'(req_ready), 32'd0);
        chk("rst_resp_valid", W'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", W'(resp_err), 32'd0);
        chk("rst_mem_adr", mem_adr, 32'd0);
        chk("rst_mem_write_data", mem_write_data, 32'd0);
        chk("rst_mem_we", W'(mem_write_enable), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", W'(req_ready), 32'd1);

        // Initialise the exercised region through the DUT
        for (int i = 0; i < 'h108; i += 4)
            do_req(1'b1, 3'b010, W'(i), $urandom, got);

        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, got);
        do_req(1'b0, 3'b010, 32'h100, '0, got);
        chk("lw_after_sw", got, 32'hDEADBEEF);
        do_req(1'b1, 3'b000, 32'h100, 32'h00000080, got);
        do_req(1'b0, 3'b010, 32'h100, '0, got);
        chk("lw_after_sb", got, 32'hDEADBE80);
        do_req(1'b0, 3'b000, 32'h100, '0, got);
        chk("lb_sign", got, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h100, '0, got);
        chk("lbu_zero", got, 32'h00000080);

        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, got);
        do_req(1'b1, 3'b001, 32'h100, 32'h00001234, got);
        do_req(1'b0, 3'b010, 32'h100, '0, got);
        chk("lw_after_sh", got, 32'hDEAD1234);
        do_req(1'b0, 3'b001, 32'h100, '0, got);
        chk("lh", got, 32'h00001234);
        do_req(1'b1, 3'b001, 32'h100, 32'h00008001, got);
        do_req(1'b0, 3'b101, 32'h100, '0, got);
        chk("lhu", got, 32'h00008001);

        do_req(1'b1, 3'b000, 32'h101, 32'h11, got);
        do_req(1'b1, 3'b000, 32'h102, 32'h22, got);
        do_req(1'b1, 3'b000, 32'h103, 32'h33, got);
        do_req(1'b1, 3'b000, 32'h104, 32'h44, got);
        do_req(1'b0, 3'b010, 32'h101, '0, got);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_misaligned_trap", got, 32'h0);
`else
        chk("lw_misaligned", got, 32'h44332211);
`endif

        // Reset asserted while the SB merge write is pending
        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, got);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h100; req_wdata = 32'h80;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("merge_we_pending", W'(mem_write_enable), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("we_drops_on_reset", W'(mem_write_enable), 32'd0);
        @(negedge clk);
        chk("no_resp_in_reset", W'(resp_valid), 32'd0);
        chk("ready_low_in_reset", W'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_abort", W'(req_ready), 32'd1);
        chk("no_resp_after_abort", W'(resp_valid), 32'd0);
        do_req(1'b0, 3'b010, 32'h100, '0, got);
        chk("word_unchanged_after_abort", got, 32'hDEADBEEF);
        do_req(1'b1, 3'b011, 32'h100, 32'h12345678, got);
        do_req(1'b0, 3'b010, 32'h100, '0, got);
        chk("illegal_store_no_write", got, 32'hDEADBEEF);

        for (int n = 0; n < 60; n++)
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   W'($urandom_range(0, 252)), $urandom, got);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

endmodule
